// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared defaults and HI/LO encodings for the scoreboarded register file
package regfile_sb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam logic HL_HI = 1'b0;
  localparam logic HL_LO = 1'b1;
  localparam int HL_WE_HI = 0;
  localparam int HL_WE_LO = 1;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one GPR read port (r0 zero, optional write-through under REGFILE_BYPASS_EN, busy mask)
module regfile_rdport
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AW = 5
) (
  input  logic [AW-1:0]     raddr,
  input  logic [DATA_W-1:0] rd_reg,
  input  logic              rd_busy,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  output logic [DATA_W-1:0] rdata,
  output logic              rbusy
);
`ifdef REGFILE_BYPASS_EN
  logic hit;
  logic clr;
  assign hit = we && waddr == raddr;
  assign clr = hit && !(sb_set && sb_addr == raddr);
  assign rdata = raddr == '0 ? '0 : hit ? wdata : rd_reg;
  assign rbusy = raddr != '0 && !clr && rd_busy;
`else
  logic unused_fwd;
  assign unused_fwd = ^{we, waddr, wdata, sb_set, sb_addr};
  assign rdata = raddr == '0 ? '0 : rd_reg;
  assign rbusy = raddr != '0 && rd_busy;
`endif
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: GPR file + HI/LO with busy scoreboard; REGFILE_BYPASS_EN enables write-through forwarding
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NRD*$clog2(NREG)-1:0] raddr,
  output logic [NRD*DATA_W-1:0]      rdata,
  output logic [NRD-1:0]             rbusy,
  input  logic                       we,
  input  logic [$clog2(NREG)-1:0]    waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       sb_set,
  input  logic [$clog2(NREG)-1:0]    sb_addr,
  input  logic                       hl_raddr,
  output logic [DATA_W-1:0]          hl_rdata,
  input  logic [1:0]                 hl_we,
  input  logic [2*DATA_W-1:0]        hl_wdata,
  input  logic                       hl_sb_set,
  output logic                       hl_busy
);
  localparam int AW = $clog2(NREG);
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [DATA_W-1:0] hi, lo;
  logic hl_busy_q;
  logic [DATA_W-1:0] hl_sel;
  assign hl_sel = hl_raddr == HL_LO ? lo : hi;
  // GPR array; r0 is never written so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end
  // scoreboard: writeback clears, a new producer set in the same cycle wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (we && waddr != '0) busy[waddr] <= 1'b0;
      if (sb_set && sb_addr != '0) busy[sb_addr] <= 1'b1;
    end
  end
  // HI/LO halves load independently; pending flag set wins over a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      hl_busy_q <= 1'b0;
    end else begin
      if (hl_we[HL_WE_HI]) hi <= hl_wdata[2*DATA_W-1:DATA_W];
      if (hl_we[HL_WE_LO]) lo <= hl_wdata[DATA_W-1:0];
      hl_busy_q <= hl_sb_set ? 1'b1 : |hl_we ? 1'b0 : hl_busy_q;
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic hl_fwd;
  assign hl_fwd = hl_raddr == HL_LO ? hl_we[HL_WE_LO] : hl_we[HL_WE_HI];
  assign hl_rdata = !hl_fwd ? hl_sel : hl_raddr == HL_LO ? hl_wdata[DATA_W-1:0] : hl_wdata[2*DATA_W-1:DATA_W];
  assign hl_busy = hl_busy_q && !(hl_fwd && !hl_sb_set);
`else
  assign hl_rdata = hl_sel;
  assign hl_busy = hl_busy_q;
`endif
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];
    regfile_rdport #(.DATA_W(DATA_W), .AW(AW)) u_rd (
      .raddr(ra),
      .rd_reg(regs[ra]),
      .rd_busy(busy[ra]),
      .we(we),
      .waddr(waddr),
      .wdata(wdata),
      .sb_set(sb_set),
      .sb_addr(sb_addr),
      .rdata(rdata[i*DATA_W +: DATA_W]),
      .rbusy(rbusy[i])
    );
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the core's integer register file: a DATA_W × NREG general-purpose file with NRD combinational read ports, one write port, and a HI/LO pair with independent per-half write enables. It adds asynchronous reset of all state and a per-register scoreboard (busy bits) so the decode stage can stall on operands whose long-latency producer (load, mul/div) has not yet written back. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- DATA_W, 32, register width.
- NREG, 32, number of GPRs; power of two; AW = $clog2(NREG).
- NRD, 2, number of read ports (1..4).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- rdata  out  NRD*DATA_W  read data; port i at [i*DATA_W +: DATA_W].
- rbusy  out  NRD  port i operand is pending (scoreboard).
- we  in  1  GPR write enable.
- waddr  in  AW  GPR write address.
- wdata  in  DATA_W  GPR write data.
- sb_set  in  1  mark sb_addr pending (producer issued).
- sb_addr  in  AW  register to mark.
- hl_raddr  in  1  0 = HI, 1 = LO.
- hl_rdata  out  DATA_W  selected HI/LO value.
- hl_we  in  2  bit0 writes HI, bit1 writes LO; both = 64-bit result.
- hl_wdata  in  2*DATA_W  {HI, LO}: HI = [2*DATA_W-1:DATA_W], LO = [DATA_W-1:0].
- hl_sb_set  in  1  mark HI/LO pending (mul/div issued).
- hl_busy  out  1  HI/LO pending.

## Operation
- GPR write: on posedge clk, if we && waddr != 0, reg[waddr] <= wdata. Writes to r0 discarded.
- Read: rdata[i] = 0 when raddr[i] == 0, else reg[raddr[i]] (bypass per Configuration).
- HI/LO write: hl_we[0] loads HI from upper half, hl_we[1] loads LO from lower half, independently, same edge.
- Scoreboard: busy[NREG-1:0]; busy[0] hard-wired 0.
  - sb_set && sb_addr != 0 -> busy[sb_addr] <= 1.
  - we && waddr != 0 -> busy[waddr] <= 0.
  - Same address, same cycle: set wins (new producer supersedes writeback) -> busy stays 1.
  - Set of an already-busy register: stays 1 (no count).
- hl_busy: set by hl_sb_set, cleared by any hl_we bit; simultaneous -> set wins.
- rbusy[i] = busy[raddr[i]], masked per Configuration.
- Reset: all GPRs, HI, LO = 0; all busy bits and hl_busy = 0. Therefore after reset rdata = 0, rbusy = 0, hl_rdata = 0, hl_busy = 0.

## Timing
- Reads and busy outputs combinational from addresses and state; zero latency.
- Write visible through array read the cycle after the write edge.
- Scoreboard set visible on rbusy the cycle after sb_set.
- rst asserted mid-operation clears all state immediately (asynchronous); writes in that cycle are lost.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding. If we && waddr == raddr[i] != 0, rdata[i] = wdata and rbusy[i] = 0 in the same cycle, unless sb_set to the same register in that cycle. If hl_we bit for the selected half is set, hl_rdata = that half of hl_wdata and hl_busy reads 0 unless hl_sb_set.
- Not defined: no forwarding; reads return stored state only, busy cleared the cycle after writeback.

## Structure
- Shared defines header: NREG/DATA_W defaults, HI/LO select encodings (HL_HI = 0, HL_LO = 1), hl_we bit positions.
- One sub-module, regfile_rdport: one read port (zero-check, bypass mux, busy mask), instantiated NRD times via generate.

## Test plan
- Reset then read r5, HI -> rdata = 0, hl_rdata = 0, rbusy = 0, hl_busy = 0.
- Write r3 = 0x1234_5678; next cycle read r3 on both ports -> 0x1234_5678; write r0 = 0xFFFF_FFFF -> r0 reads 0.
- sb_set r7, two idle cycles, then we r7 = 0xA5 -> rbusy = 1 until write edge, 0 after; with bypass, rdata = 0xA5 and rbusy = 0 in the write cycle.
- Same-cycle sb_set r9 and we r9 = 0x11 -> r9 = 0x11, busy[r9] = 1 next cycle.
- hl_we = 2'b01 with hl_wdata = {0xDEAD_BEEF, 0x0000_0001} -> HI = 0xDEAD_BEEF, LO unchanged (0); hl_we = 2'b11 loads both.
- rst pulsed mid-sequence with r4 busy and HI nonzero -> all zero and not busy immediately, before next clk edge.
